// File: rtl/frogger_traffic_core.sv
// Traffic/raster core: rebuilds pixel col/row from syncs, steps five cars, flags frog hits and car tiles.
// Latency: syncs, counters, car X and collision are 1 clock; o_Car_Pixel is combinational from registers.
// Backpressure: none; free-running every clock, no stall input.
//
// Ports: i_Clk/i_Rst_L clock and async active-low reset; i_HSync/i_VSync raw syncs in,
// o_HSync/o_VSync one-clock delayed copies; i_Frogger_X/Y frog tile; o_Col_Count/o_Row_Count
// raster position; o_Car_X/o_Car_Y packed 6-bit car tiles (car n at [6n-1:6n-6]);
// o_Car_Pixel raster tile holds a car; o_Collided frog shares a tile with any car.
module frogger_traffic_core #(
    parameter int TOTAL_COLS   = 800,
    parameter int TOTAL_ROWS   = 525,
    parameter int MAX_X        = 14,
    parameter int CAR_SPEED    = 1,
    parameter int SLOW_COUNT_1 = 4000000,
    parameter int SLOW_COUNT_2 = 5000000,
    parameter int SLOW_COUNT_3 = 3700000,
    parameter int SLOW_COUNT_4 = 4500000,
    parameter int SLOW_COUNT_5 = 4200000,
    parameter int INIT_Y_1     = 11,
    parameter int INIT_Y_2     = 10,
    parameter int INIT_Y_3     = 9,
    parameter int INIT_Y_4     = 8,
    parameter int INIT_Y_5     = 7
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_HSync,
    input  logic        i_VSync,
    input  logic [5:0]  i_Frogger_X,
    input  logic [5:0]  i_Frogger_Y,
    output logic        o_HSync,
    output logic        o_VSync,
    output logic [9:0]  o_Col_Count,
    output logic [9:0]  o_Row_Count,
    output logic [29:0] o_Car_X,
    output logic [29:0] o_Car_Y,
    output logic        o_Car_Pixel,
    output logic        o_Collided
);

    localparam int NUM_CARS = 5;
    localparam int SLOW_COUNT [NUM_CARS] = '{SLOW_COUNT_1, SLOW_COUNT_2, SLOW_COUNT_3,
                                             SLOW_COUNT_4, SLOW_COUNT_5};
    localparam int INIT_Y [NUM_CARS]     = '{INIT_Y_1, INIT_Y_2, INIT_Y_3, INIT_Y_4, INIT_Y_5};

    localparam logic [9:0] LAST_COL = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] LAST_ROW = 10'(TOTAL_ROWS - 1);

    // Rising edge of VSync, seen against the delayed copy.
    logic frame_start;
    assign frame_start = i_VSync & ~o_VSync;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_HSync <= 1'b0;
            o_VSync <= 1'b0;
        end else begin
            o_HSync <= i_HSync;
            o_VSync <= i_VSync;
        end
    end

    // Frame start wins over the normal increment/wrap.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Col_Count <= '0;
            o_Row_Count <= '0;
        end else if (frame_start) begin
            o_Col_Count <= '0;
            o_Row_Count <= '0;
        end else if (o_Col_Count == LAST_COL) begin
            o_Col_Count <= '0;
            o_Row_Count <= (o_Row_Count == LAST_ROW) ? 10'd0 : o_Row_Count + 10'd1;
        end else begin
            o_Col_Count <= o_Col_Count + 10'd1;
        end
    end

    // Raster tile, zero-extended to the 6-bit car coordinate width.
    logic [5:0] tile_col;
    logic [5:0] tile_row;
    assign tile_col = {1'b0, o_Col_Count[9:5]};
    assign tile_row = {1'b0, o_Row_Count[9:5]};

    logic [NUM_CARS-1:0] hit_frog;
    logic [NUM_CARS-1:0] hit_tile;

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
        localparam logic [31:0] LAST_TICK = 32'(SLOW_COUNT[g] - 1);
        localparam logic [5:0]  CAR_Y     = 6'(INIT_Y[g]);

        logic [31:0] prescale_q;
        logic [5:0]  x_q;
        logic [6:0]  next_x;

        // One extra bit so a step past the lane end is seen rather than wrapping silently.
        assign next_x = {1'b0, x_q} + 7'(CAR_SPEED);

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                prescale_q <= '0;
                x_q        <= '0;
            end else if (prescale_q == LAST_TICK) begin
                prescale_q <= '0;
                x_q        <= (next_x >= 7'(MAX_X)) ? 6'd0 : next_x[5:0];
            end else begin
                prescale_q <= prescale_q + 32'd1;
            end
        end

        assign o_Car_X[6*g +: 6] = x_q;
        assign o_Car_Y[6*g +: 6] = CAR_Y;
        assign hit_frog[g]       = (x_q == i_Frogger_X) && (CAR_Y == i_Frogger_Y);
        assign hit_tile[g]       = (x_q == tile_col) && (CAR_Y == tile_row);
    end

    // Compares pre-edge car positions, so a car move shows up one clock later.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Collided <= 1'b0;
        end else begin
            o_Collided <= |hit_frog;
        end
    end

    assign o_Car_Pixel = |hit_tile;

endmodule

// File: tb/tb_frogger_traffic_core.sv
module tb_frogger_traffic_core;

    localparam int COLS  = 100;
    localparam int ROWS  = 330;
    localparam int MAXX  = 14;
    localparam int SLOW [5] = '{3, 5, 4, 7, 2};
    // Car 5 shares car 1's lane so two cars can sit on the frog at once.
    localparam int LANE [5] = '{11, 10, 9, 8, 11};

    logic        clk;
    logic        rst_n;
    logic        hs;
    logic        vs;
    logic [5:0]  fx;
    logic [5:0]  fy;
    logic        o_hs;
    logic        o_vs;
    logic [9:0]  col;
    logic [9:0]  row;
    logic [29:0] car_x;
    logic [29:0] car_y;
    logic        car_pix;
    logic        coll;

    frogger_traffic_core #(
        .TOTAL_COLS(COLS), .TOTAL_ROWS(ROWS), .MAX_X(MAXX), .CAR_SPEED(1),
        .SLOW_COUNT_1(3), .SLOW_COUNT_2(5), .SLOW_COUNT_3(4), .SLOW_COUNT_4(7), .SLOW_COUNT_5(2),
        .INIT_Y_1(11), .INIT_Y_2(10), .INIT_Y_3(9), .INIT_Y_4(8), .INIT_Y_5(11)
    ) u_dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(hs), .i_VSync(vs),
        .i_Frogger_X(fx), .i_Frogger_Y(fy),
        .o_HSync(o_hs), .o_VSync(o_vs), .o_Col_Count(col), .o_Row_Count(row),
        .o_Car_X(car_x), .o_Car_Y(car_y), .o_Car_Pixel(car_pix), .o_Collided(coll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: clock edges since reset release, pixels since last frame start.
    int cyc;
    int pix;
    bit prev_h;
    bit prev_v;
    bit exp_coll;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Car n has made cyc/SLOW steps; with speed 1 the lane wrap is plain modulo.
    function automatic int model_x(int n);
        return (cyc / SLOW[n]) % MAXX;
    endfunction

    function automatic bit frog_hit();
        bit hit = 1'b0;
        for (int n = 0; n < 5; n++)
            if (model_x(n) == int'(fx) && LANE[n] == int'(fy)) hit = 1'b1;
        return hit;
    endfunction

    task automatic model_reset();
        cyc = 0; pix = 0; prev_h = 1'b0; prev_v = 1'b0; exp_coll = 1'b0;
    endtask

    task automatic check_all();
        logic [29:0] ex;
        logic [29:0] ey;
        int ecol;
        int erow;
        bit epix;
        ecol = pix % COLS;
        erow = (pix / COLS) % ROWS;
        epix = 1'b0;
        for (int n = 0; n < 5; n++) begin
            ex[6*n +: 6] = 6'(model_x(n));
            ey[6*n +: 6] = 6'(LANE[n]);
            if (model_x(n) == ecol / 32 && LANE[n] == erow / 32) epix = 1'b1;
        end
        check_eq("hsync", 32'(o_hs), 32'(prev_h));
        check_eq("vsync", 32'(o_vs), 32'(prev_v));
        check_eq("col", 32'(col), 32'(ecol));
        check_eq("row", 32'(row), 32'(erow));
        check_eq("car_x", 32'(car_x), 32'(ex));
        check_eq("car_y", 32'(car_y), 32'(ey));
        check_eq("collided", 32'(coll), 32'(exp_coll));
        check_eq("car_pixel", 32'(car_pix), 32'(epix));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            exp_coll = frog_hit();
            if (vs && !prev_v) pix = 0;
            else pix++;
            prev_h = hs;
            prev_v = vs;
            cyc++;
        end
        #1;
        check_all();
    endtask

    // Half the time park the frog on a car's current tile so collisions are frequent.
    task automatic drive_frog();
        int r;
        if ($urandom_range(0, 1) == 0) begin
            r  = $urandom_range(0, 4);
            fx = 6'(model_x(r));
            fy = 6'(LANE[r]);
        end else begin
            fx = 6'($urandom_range(0, 15));
            fy = 6'($urandom_range(5, 13));
        end
    endtask

    initial begin
        rst_n = 1'b0; hs = 1'b0; vs = 1'b0; fx = 6'd0; fy = 6'd11;
        model_reset();
        #3;
        check_all();
        repeat (3) begin
            hs = 1'($urandom); vs = 1'($urandom);
            tick();
        end
        hs = 1'b0; vs = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Random syncs including frequent frame starts.
        for (int i = 0; i < 1500; i++) begin
            hs = 1'($urandom);
            vs = ($urandom_range(0, 19) == 0);
            drive_frog();
            tick();
        end

        // One clean frame start, then a full frame plus a row wrap.
        vs = 1'b0; tick();
        vs = 1'b1; tick();
        vs = 1'b0;
        for (int i = 0; i < 33200; i++) begin
            hs = 1'($urandom);
            drive_frog();
            tick();
        end

        // Async reset between edges: outputs must clear without a clock.
        fx = 6'(model_x(0)); fy = 6'(LANE[0]);
        tick();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) tick();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            hs = 1'($urandom);
            vs = ($urandom_range(0, 49) == 0);
            drive_frog();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frogger_traffic_core.md
# frogger_traffic_core

Traffic and raster core of the Frogger game. It regenerates VGA column/row counters from incoming sync pulses and moves five cars horizontally across road lanes. It detects frog/car tile overlaps and flags the pixel tiles occupied by cars. It sits between the VGA sync generator and the frog controller / video mux in the top level.

## Interface
Parameters:
- TOTAL_COLS, 800, pixel clocks per line.
- TOTAL_ROWS, 525, lines per frame.
- MAX_X, 14, number of tile columns a car traverses; valid X is 0..MAX_X-1.
- CAR_SPEED, 1, tiles advanced per car step.
- SLOW_COUNT_1..SLOW_COUNT_5, 4000000 / 5000000 / 3700000 / 4500000 / 4200000, clocks between steps for cars 1..5.
- INIT_Y_1..INIT_Y_5, 11 / 10 / 9 / 8 / 7, fixed lane (tile row) of cars 1..5; all cars start at X=0.

Ports:
- i_Clk  in  1  system/pixel clock.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_HSync  in  1  horizontal sync from the sync generator.
- i_VSync  in  1  vertical sync from the sync generator.
- i_Frogger_X  in  6  frog tile column.
- i_Frogger_Y  in  6  frog tile row.
- o_HSync  out  1  i_HSync delayed one clock.
- o_VSync  out  1  i_VSync delayed one clock.
- o_Col_Count  out  10  current pixel column.
- o_Row_Count  out  10  current pixel row.
- o_Car_X  out  30  car X positions, car n at bits [6n-1:6n-6].
- o_Car_Y  out  30  car Y positions, same packing, constant INIT_Y_n.
- o_Car_Pixel  out  1  current raster tile (Col[9:5], Row[9:5]) holds a car; combinational from the registered counters and positions.
- o_Collided  out  1  frog tile equals some car tile.

## Operation
- Sync-to-count:
  - Register i_HSync and i_VSync into o_HSync and o_VSync.
  - Frame start is the VSync rising edge, i_VSync=1 while o_VSync=0. On frame start, set col and row to 0.
  - Otherwise col increments each clock. When col=TOTAL_COLS-1, col wraps to 0 and row increments.
  - When row=TOTAL_ROWS-1 and col wraps, row wraps to 0.
- Car n:
  - A prescaler counts 0..SLOW_COUNT_n-1. At terminal count it returns to 0 and the car steps.
  - On a step, next_x = X+CAR_SPEED. If next_x ≥ MAX_X, X becomes 0; otherwise X = next_x.
  - Y never changes. Cars are independent.
- Collision: o_Collided is registered and equals OR over n of (Car_X_n==i_Frogger_X && Car_Y_n==i_Frogger_Y).
  - The comparison uses register values before the current edge's update.
  - Several cars matching at once still yields a single 1.
- Tile mapping: tile = pixel_count[9:5] (32-pixel tiles). o_Car_Pixel compares the 5-bit tile with the 6-bit car coordinate, zero-extended.

## Timing
- Reset (async assert, sync release) clears the following: o_HSync=0, o_VSync=0, col=0, row=0, all prescalers=0, all Car_X=0, o_Collided=0. Car_Y holds INIT_Y_n at all times.
- Sync outputs: latency 1 clock.
- Counters: a VSync rise sampled at edge k gives col=row=0 after edge k; col=1 after edge k+1.
- Car n first steps on the SLOW_COUNT_n-th edge after reset release, then every SLOW_COUNT_n edges.
- o_Collided: 1-clock latency from frog input change or car move.
- A frame-start edge takes priority over counter increment/wrap in the same cycle.
- Reset mid-operation returns all cars to X=0 and restarts their prescalers.

## Test plan
- Reset: with i_Rst_L=0, all outputs match the reset values and Car_Y packs 11,10,9,8,7. Releasing reset leaves them unchanged for SLOW_COUNT-1 clocks.
- Counters (TOTAL_COLS=10, TOTAL_ROWS=5): pulse VSync 0→1. After 1 clock col=0,row=0; after 10 clocks col=0,row=1; after 50 clocks row wraps to 0.
- Car stepping (SLOW_COUNT_1=3, MAX_X=14): X=1 after 3 clocks, 2 after 6. After 13 steps X=13; the 14th step wraps X to 0.
- Collision: frog=(4,11) while car1 X reaches 4, giving o_Collided=1 one clock later. Move frog to (4,12), giving 0 one clock later. Two cars matching the frog at once give a single 1.
- o_Car_Pixel: car3 at X=2 (Y=9), counters col=64..95, row=288..319, giving 1. col=96 gives 0.
- Async reset mid-run: drop i_Rst_L between clock edges with cars at nonzero X. X=0 and o_Collided=0 immediately, without waiting for a clock.
